tia_frame_capture: RTL



---
 rtl/tia_frame_capture_if.sv | 16 +
 rtl/tia_frame_capture.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tia_frame_capture_if.sv
// Pixel stream from tia_frame_capture to a framebuffer writer or host capture.
//   px_valid : FIFO head holds a pixel
//   px_ready : consumer takes the head when px_valid & px_ready
//   px_data  : {c[3:0], l[2:0]} of the head pixel
//   px_x     : head pixel column
//   px_y     : head pixel row
interface tia_frame_capture_if;
  logic       px_valid;
  logic       px_ready;
  logic [6:0] px_data;
  logic [7:0] px_x;
  logic [8:0] px_y;

  modport master (output px_valid, output px_data, output px_x, output px_y, input px_ready);
  modport slave  (input px_valid, input px_data, input px_x, input px_y, output px_ready);
endinterface

// File: rtl/tia_frame_capture.sv
// Captures TIA video pins, recovers frame/line timing from composite sync and
// emits numbered visible pixels through a small FIFO.
//   clk         : TIA colour clock, rising edge
//   reset       : asynchronous, active-high
//   syn         : composite sync
//   blk_bar     : blank, active-low (1 = visible pixel)
//   l, c        : luminance / colour
//   px          : pixel stream (valid/ready, data, x, y)
//   frame_start : one-clock pulse when vertical sync is qualified
//   overflow    : sticky, a pixel was dropped because the FIFO was full
//   locked      : first vertical sync seen since reset
module tia_frame_capture #(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 262,
  parameter int unsigned VSYNC_MIN  = 456,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       syn,
  input  logic                       blk_bar,
  input  logic [2:0]                 l,
  input  logic [3:0]                 c,
  tia_frame_capture_if.master        px,
  output logic                       frame_start,
  output logic                       overflow,
  output logic                       locked
);

  localparam int unsigned RunW = $clog2(VSYNC_MIN + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StSeekVsync, StWaitLine, StActive} state_e;

  // Input sample stage
  logic       syn_q, blk_q;
  logic [6:0] pix_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syn_q <= 1'b0;
      blk_q <= 1'b0;
      pix_q <= '0;
    end else begin
      syn_q <= syn;
      blk_q <= blk_bar;
      pix_q <= {c, l};
    end
  end

  state_e          state_q;
  logic [RunW-1:0] run_q;
  logic [7:0]      x_q;
  logic [8:0]      y_q;
  logic            seen_q;   // at least one pixel on the current line

  logic       vsync_hit, hsync_end, in_line, pixel, wr_req;
  logic [7:0] x_base, x_next;
  logic [8:0] y_base;
  logic       seen_base;

  assign vsync_hit = syn_q && (run_q == RunW'(VSYNC_MIN - 1));
  // A falling edge after a full vsync run is not a line boundary.
  assign hsync_end = !syn_q && (run_q != '0) && (run_q < RunW'(VSYNC_MIN));

  // Apply the line boundary first so a pixel on the first clock after sync
  // belongs to the new line.
  always_comb begin
    x_base    = x_q;
    y_base    = y_q;
    seen_base = seen_q;
    if (hsync_end && (state_q == StActive || state_q == StWaitLine)) begin
      x_base    = '0;
      seen_base = 1'b0;
      if (state_q == StActive && seen_q && y_q != 9'h1ff) y_base = y_q + 9'd1;
    end
    in_line = (state_q == StActive) || (state_q == StWaitLine && hsync_end);
    pixel   = in_line && blk_q && !syn_q;
    wr_req  = pixel && (32'(x_base) < WIDTH) && (32'(y_base) < HEIGHT);
    x_next  = (pixel && x_base != 8'hff) ? x_base + 8'd1 : x_base;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StSeekVsync;
      run_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      seen_q      <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!syn_q)                           run_q <= '0;
      else if (run_q < RunW'(VSYNC_MIN))    run_q <= run_q + RunW'(1);

      if (vsync_hit) begin
        state_q     <= StWaitLine;
        frame_start <= 1'b1;
        locked      <= 1'b1;
        x_q         <= '0;
        y_q         <= '0;
        seen_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StSeekVsync: ;
          StWaitLine, StActive: begin
            if (hsync_end) state_q <= StActive;
            x_q    <= x_next;
            y_q    <= y_base;
            seen_q <= seen_base | pixel;
          end
          default: state_q <= StSeekVsync;
        endcase
      end
    end
  end

  // Output FIFO: {data, x, y}
  logic [23:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            full, empty, push, pop;

  assign full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && px.px_ready;
  // A pop on the same clock frees the slot for the incoming pixel.
  assign push  = wr_req && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {pix_q, x_base, y_base};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
      if (wr_req && full && !pop) overflow <= 1'b1;
    end
  end

  assign px.px_valid = !empty;
  assign px.px_data  = mem_q[rd_ptr_q][23:17];
  assign px.px_x     = mem_q[rd_ptr_q][16:9];
  assign px.px_y     = mem_q[rd_ptr_q][8:0];

endmodule
